// File: rtl/stk_seq_ctrl_if.sv
// Bus bundle between the instruction sequencer and its surroundings:
// the instruction ROM port plus launch/completion handshakes to WBPB and the stack ALU.
interface stk_seq_ctrl_if #(
    parameter int ADDR_LEN = 8,
    parameter int DATA_LEN = 8
);
    logic [ADDR_LEN-1:0]   inst_addr;
    logic                  inst_r_en;
    logic [DATA_LEN+3:0]   inst_data;
    logic [3:0]            control_bus;
    logic [DATA_LEN-1:0]   addr_const;
    logic                  wbpb_en;
    logic                  wbpb_fin;
    logic                  alu_en;
    logic                  alu_fin;
    logic [DATA_LEN-1:0]   stk_top;

    modport master (
        output inst_addr, inst_r_en, control_bus, addr_const, wbpb_en, alu_en,
        input  inst_data, wbpb_fin, alu_fin, stk_top
    );

    modport slave (
        input  inst_addr, inst_r_en, control_bus, addr_const, wbpb_en, alu_en,
        output inst_data, wbpb_fin, alu_fin, stk_top
    );
endinterface

// File: rtl/stk_seq_ctrl.sv
// Instruction sequencer: fetches {opcode,operand} words, launches WBPB/ALU operations
// and waits for their completion, and executes JMP/JZ/HALT internally.
module stk_seq_ctrl #(
    parameter int ADDR_LEN = 8,
    parameter int DATA_LEN = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    stk_seq_ctrl_if.master      seq,
    output logic [ADDR_LEN-1:0] pc,
    output logic                busy,
    output logic                halted,
    output logic                err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JZ   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ROMWAIT,
        S_DECODE,
        S_ISSUE,
        S_WAITFIN,
        S_HALT,
        S_ERROR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_LEN-1:0]  pc_next;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_next;
    logic [3:0]           ir_opc;
    logic [DATA_LEN-1:0]  ir_operand;
    logic [3:0]           cb_q;
    logic [DATA_LEN-1:0]  ac_q;
    logic                 ir_load;
    logic                 decode_load;
    logic                 is_unit_op;
    logic                 fin_seen;
    logic [ADDR_LEN-1:0]  jump_target;

    assign is_unit_op  = (ir_opc <= 4'd2) || (ir_opc[3:2] == 2'b01);
    assign jump_target = ADDR_LEN'(ir_operand);

    // Bit 2 of the latched opcode tells which unit was launched; only its fin counts.
    assign fin_seen = cb_q[2] ? seq.alu_fin : seq.wbpb_fin;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        timer_next  = timer;
        ir_load     = 1'b0;
        decode_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_ROMWAIT;
            end
            S_ROMWAIT: begin
                ir_load    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                decode_load = 1'b1;
                if (is_unit_op) begin
                    state_next = S_ISSUE;
                end else if (ir_opc == OP_JMP) begin
                    pc_next    = jump_target;
                    state_next = S_FETCH;
                end else if (ir_opc == OP_JZ) begin
                    pc_next    = (seq.stk_top == '0) ? jump_target : pc + ADDR_LEN'(1);
                    state_next = S_FETCH;
                end else if (ir_opc == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_ERROR;
                end
            end
            S_ISSUE: begin
                timer_next = '0;
                state_next = S_WAITFIN;
            end
            S_WAITFIN: begin
                if (fin_seen) begin
                    pc_next    = pc + ADDR_LEN'(1);
                    state_next = S_FETCH;
                end else begin
                    timer_next = timer + TW'(1);
                    if (timer == TW'(TIMEOUT - 1)) begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH;
                end
            end
            S_ERROR: begin
                state_next = S_ERROR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // control_bus/addr_const stay registered from DECODE until the next decode,
    // so units can keep reading them while they work.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc         <= '0;
            timer      <= '0;
            ir_opc     <= '0;
            ir_operand <= '0;
            cb_q       <= '0;
            ac_q       <= '0;
        end else begin
            pc    <= pc_next;
            timer <= timer_next;
            if (ir_load) begin
                {ir_opc, ir_operand} <= seq.inst_data;
            end
            if (decode_load) begin
                cb_q <= ir_opc;
                ac_q <= ir_operand;
            end
        end
    end

    assign seq.inst_r_en   = (state == S_FETCH);
    assign seq.inst_addr   = (state == S_FETCH) ? pc : '0;
    assign seq.control_bus = cb_q;
    assign seq.addr_const  = ac_q;
    assign seq.wbpb_en     = (state == S_ISSUE) && !cb_q[2];
    assign seq.alu_en      = (state == S_ISSUE) && cb_q[2];

    assign busy   = (state == S_FETCH) || (state == S_ROMWAIT) || (state == S_DECODE) ||
                    (state == S_ISSUE) || (state == S_WAITFIN);
    assign halted = (state == S_HALT);
    assign err    = (state == S_ERROR);

endmodule

// File: tb/tb_stk_seq_ctrl.sv
// Bench for stk_seq_ctrl: ROM and unit responders plus an instruction-level
// interpreter that predicts the launches and the final status of each program.
module tb_stk_seq_ctrl;

    typedef struct {
        logic [7:0] pc;
        bit         isAlu;
        logic [3:0] cb;
        logic [7:0] ac;
    } launch_t;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       err;

    stk_seq_ctrl_if #(.ADDR_LEN(8), .DATA_LEN(8)) bif ();

    stk_seq_ctrl #(.ADDR_LEN(8), .DATA_LEN(8), .TIMEOUT(16)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .seq    (bif),
        .pc     (pc),
        .busy   (busy),
        .halted (halted),
        .err    (err)
    );

    logic [11:0] rom [256];
    launch_t     expQ[$];
    launch_t     dutQ[$];
    launch_t     held;
    logic [7:0]  expPc;
    bit          expHalt;
    bit          expErr;
    bit          suppressFin;
    int          wrongFinPct;
    bit          waiting;
    bit          prevEn;
    int          sinceFetch;
    int          vectorCount;
    int          miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bif.inst_r_en) bif.inst_data <= rom[bif.inst_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Unit models: answer a launch with a fin 2..5 cycles later, sometimes preceded by a
    // stray fin from the other unit which the sequencer must ignore.
    always begin
        @(negedge clk);
        if (rstn && (bif.wbpb_en || bif.alu_en) && !suppressFin) begin
            automatic bit isAlu = bif.alu_en;
            automatic int d = $urandom_range(5, 2);
            if ($urandom_range(99, 0) < wrongFinPct) begin
                @(posedge clk); #1;
                if (isAlu) bif.wbpb_fin = 1'b1; else bif.alu_fin = 1'b1;
                @(posedge clk); #1;
                bif.wbpb_fin = 1'b0;
                bif.alu_fin  = 1'b0;
                repeat (d - 2) @(posedge clk);
            end else begin
                repeat (d) @(posedge clk);
            end
            #1;
            if (isAlu) bif.alu_fin = 1'b1; else bif.wbpb_fin = 1'b1;
            @(posedge clk); #1;
            bif.wbpb_fin = 1'b0;
            bif.alu_fin  = 1'b0;
        end
    end

    // Launch monitor: pulse shape, fetch-to-launch latency, operand stability while waiting.
    always @(negedge clk) begin
        if (!rstn) begin
            waiting    = 1'b0;
            sinceFetch = 0;
            prevEn     = 1'b0;
        end else begin
            if (waiting) begin
                checkOutput("cb_hold", bif.control_bus, held.cb);
                checkOutput("ac_hold", bif.addr_const, held.ac);
                checkOutput("pc_hold", pc, held.pc);
                if (held.isAlu ? bif.alu_fin : bif.wbpb_fin) waiting = 1'b0;
            end
            if (bif.inst_r_en) sinceFetch = 1;
            else if (sinceFetch != 0) sinceFetch++;
            if (bif.wbpb_en || bif.alu_en) begin
                checkOutput("en_excl", bif.wbpb_en & bif.alu_en, 0);
                checkOutput("en_1cyc", prevEn, 0);
                checkOutput("latency", sinceFetch, 4);
                sinceFetch = 0;
                held = '{pc, bif.alu_en, bif.control_bus, bif.addr_const};
                dutQ.push_back(held);
                waiting = 1'b1;
            end
            prevEn = bif.wbpb_en || bif.alu_en;
        end
    end

    // Instruction-level interpreter of the current ROM contents starting at address 0.
    task automatic runModel(input logic [7:0] stkTopVal);
        logic [7:0] mpc;
        logic [3:0] op;
        logic [7:0] arg;
        int steps;
        mpc = 8'h00;
        steps = 0;
        expQ.delete();
        expHalt = 1'b0;
        expErr  = 1'b0;
        while (steps < 1000 && !expHalt && !expErr) begin
            op  = rom[mpc][11:8];
            arg = rom[mpc][7:0];
            steps++;
            if (op <= 4'd2 || (op >= 4'd4 && op <= 4'd7)) begin
                expQ.push_back('{mpc, (op >= 4'd4), op, arg});
                mpc = mpc + 8'd1;
            end else if (op == 4'd8) begin
                mpc = arg;
            end else if (op == 4'd9) begin
                mpc = (stkTopVal == 8'd0) ? arg : mpc + 8'd1;
            end else if (op == 4'd15) begin
                expHalt = 1'b1;
            end else begin
                expErr = 1'b1;
            end
        end
        expPc = mpc;
    endtask

    task automatic clearRom();
        for (int a = 0; a < 256; a++) rom[a] = 12'hF00;
    endtask

    task automatic doReset();
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic pulseStart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pc"}, pc, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_halted"}, halted, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_wbpb_en"}, bif.wbpb_en, 0);
        checkOutput({tag, "_alu_en"}, bif.alu_en, 0);
        checkOutput({tag, "_r_en"}, bif.inst_r_en, 0);
        checkOutput({tag, "_cb"}, bif.control_bus, 0);
        checkOutput({tag, "_ac"}, bif.addr_const, 0);
    endtask

    // Runs the program in rom from a start pulse and compares launches and final status.
    task automatic applyStimulus(input string tag, input logic [7:0] stkTopVal);
        int n;
        bif.stk_top = stkTopVal;
        runModel(stkTopVal);
        dutQ.delete();
        pulseStart();
        n = 0;
        while (!(halted || err) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, halted || err, 1);
        checkOutput({tag, "_halted"}, halted, expHalt);
        checkOutput({tag, "_err"}, err, expErr);
        if (expHalt) checkOutput({tag, "_pc"}, pc, expPc);
        checkOutput({tag, "_nlaunch"}, dutQ.size(), expQ.size());
        for (int i = 0; i < dutQ.size() && i < expQ.size(); i++) begin
            checkOutput({tag, "_l_pc"}, dutQ[i].pc, expQ[i].pc);
            checkOutput({tag, "_l_unit"}, dutQ[i].isAlu, expQ[i].isAlu);
            checkOutput({tag, "_l_cb"}, dutQ[i].cb, expQ[i].cb);
            checkOutput({tag, "_l_ac"}, dutQ[i].ac, expQ[i].ac);
        end
    endtask

    task automatic randomProgram();
        int nInst;
        logic [3:0] op;
        int unitOps [7] = '{0, 1, 2, 4, 5, 6, 7};
        int badOps  [6] = '{3, 10, 11, 12, 13, 14};
        int pick;
        clearRom();
        nInst = $urandom_range(12, 3);
        for (int a = 0; a < nInst - 1; a++) begin
            pick = $urandom_range(99, 0);
            if (pick < 70) begin
                op = 4'(unitOps[$urandom_range(6, 0)]);
                rom[a] = {op, 8'($urandom_range(255, 0))};
            end else if (pick < 85) begin
                rom[a] = {4'h8, 8'($urandom_range(nInst - 1, a + 1))};
            end else begin
                rom[a] = {4'h9, 8'($urandom_range(nInst - 1, a + 1))};
            end
        end
        if ($urandom_range(9, 0) == 0) rom[nInst - 1] = {4'(badOps[$urandom_range(5, 0)]), 8'h00};
        else rom[nInst - 1] = 12'hF00;
    endtask

    initial begin
        int n;
        vectorCount = 0;
        miscompares = 0;
        suppressFin = 1'b0;
        wrongFinPct = 0;
        rstn  = 1'b0;
        start = 1'b0;
        bif.inst_data = '0;
        bif.wbpb_fin  = 1'b0;
        bif.alu_fin   = 1'b0;
        bif.stk_top   = '0;
        clearRom();
        #1 checkAllZero("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        rom[0] = 12'h005;
        rom[1] = 12'hF00;
        applyStimulus("pushc_halt", 8'h00);

        clearRom();
        rom[0] = 12'h103;
        rom[1] = 12'h207;
        rom[2] = 12'h45A;
        rom[3] = 12'hF00;
        wrongFinPct = 50;
        applyStimulus("pushm_pop_add", 8'h00);

        clearRom();
        rom[0]    = 12'h910;
        rom[1]    = 12'hF00;
        rom[8'h10] = 12'h001;
        rom[8'h11] = 12'hF00;
        applyStimulus("jz_taken", 8'h00);
        applyStimulus("jz_not_taken", 8'h01);

        clearRom();
        rom[0]     = 12'h902;
        rom[1]     = 12'hF00;
        rom[2]     = 12'h8FF;
        rom[8'hFF] = 12'h009;
        bif.stk_top = 8'h00;
        pulseStart();
        n = 0;
        while (!bif.wbpb_en && n < 40) begin @(negedge clk); n++; end
        checkOutput("wrap_launch_pc", pc, 8'hFF);
        bif.stk_top = 8'h01;
        n = 0;
        while (!bif.inst_r_en && n < 40) begin @(negedge clk); n++; end
        checkOutput("wrap_fetch_addr", bif.inst_addr, 8'h00);
        n = 0;
        while (!halted && n < 100) begin @(negedge clk); n++; end
        checkOutput("wrap_halt_pc", pc, 8'h01);

        clearRom();
        rom[0] = 12'h001;
        suppressFin = 1'b1;
        pulseStart();
        n = 0;
        while (!bif.wbpb_en && n < 40) begin @(negedge clk); n++; end
        checkOutput("to_launch", bif.wbpb_en, 1);
        repeat (16) @(negedge clk);
        checkOutput("to_err_early", err, 0);
        checkOutput("to_busy_late", busy, 1);
        @(negedge clk);
        checkOutput("to_err", err, 1);
        checkOutput("to_busy", busy, 0);
        pulseStart();
        repeat (4) @(negedge clk);
        checkOutput("to_err_sticky", err, 1);
        checkOutput("to_no_fetch", bif.inst_r_en, 0);
        doReset();
        checkOutput("to_err_cleared", err, 0);

        suppressFin = 1'b0;
        clearRom();
        rom[0] = 12'hA00;
        applyStimulus("illegal", 8'h00);
        doReset();

        clearRom();
        rom[0] = 12'h003;
        suppressFin = 1'b1;
        pulseStart();
        n = 0;
        while (!bif.wbpb_en && n < 40) begin @(negedge clk); n++; end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        #1 checkAllZero("midreset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        suppressFin = 1'b0;
        rom[1] = 12'h5C3;
        rom[2] = 12'hF00;
        applyStimulus("after_reset", 8'h00);

        wrongFinPct = 30;
        for (int p = 0; p < 25; p++) begin
            randomProgram();
            applyStimulus("rand", ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1)));
            if (err) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
